serial_adder: RTL
=================

Name: serial_adder

Overview:
- Bit-serial unsigned adder: the addition counterpart to the team's combinational subtractor cells.
- Accepts two WIDTH-bit operands on a start strobe. Adds them LSB-first, one bit per clock, through a single full-adder slice and a carry flip-flop.
- Presents the WIDTH-bit sum and carry-out with a one-cycle done pulse.
- Serves as the area-minimal arithmetic primitive for the practice datapath library, exercised by the same style of self-checking bench as the combinational cells.

Parameters:
WIDTH, 4, operand and sum width in bits; legal range 1..32

Ports:
clk  input  1  single system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request strobe; sampled only in IDLE
a  input  WIDTH  addend A; captured on accepted start
b  input  WIDTH  addend B; captured on accepted start
sum  output  WIDTH  result register; valid while done=1 and held until next accepted start
cout  output  1  carry-out of MSB; same validity as sum
busy  output  1  high while operation in progress (SHIFT state)
done  output  1  one-cycle pulse marking sum/cout valid

Behaviour:
- Clocking and reset:
  - Single clock; reset is synchronous and active-high (rst sampled on clk rising edge).
  - rst=1 at any edge forces: state=IDLE, sum=0, cout=0, busy=0, done=0, internal shift regs=0, carry=0, bit counter=0.
  - rst has priority over start and over any in-flight operation. A reset mid-SHIFT aborts the operation and never produces a done pulse.
- State machine: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0, done=0.
  - On an edge with start=1: load a_sh<=a, b_sh<=b, carry<=0, cnt<=0, sum<=0, cout<=0; go to SHIFT.
  - start=0: stay in IDLE; sum/cout hold.
- SHIFT:
  - busy=1.
  - Each edge computes s = a_sh[0] ^ b_sh[0] ^ carry and c = majority(a_sh[0], b_sh[0], carry).
  - sum <= {s, sum[WIDTH-1:1]}; a_sh, b_sh shift right, zero-filling the MSB; carry <= c; cnt <= cnt+1.
  - On the edge where cnt==WIDTH-1 (the last bit): also cout <= c; go to DONE.
  - start and the a/b inputs are ignored throughout SHIFT.
- DONE:
  - done=1, busy=0 for exactly one cycle; next edge goes to IDLE unconditionally.
  - start during DONE is ignored; the earliest new accept is the edge after DONE.
- Latency:
  - start accepted at edge k: busy is high for cycles k+1..k+WIDTH.
  - done is high in the cycle following edge k+WIDTH, i.e. WIDTH+1 edges after the accepting edge.
  - Minimum issue interval is WIDTH+2 cycles.
- Arithmetic: {cout, sum} == a + b (unsigned, WIDTH+1 bits). No overflow flag beyond cout.
- Counter: cnt is ceil(log2(WIDTH))-bit wide, with a minimum of 1 bit.
- WIDTH=1: SHIFT lasts one cycle; sum=a^b, cout=a&b.
- Output holding:
  - sum/cout are undefined-by-contract during SHIFT; they shift visibly.
  - After DONE, sum/cout hold stable until the next accepted start clears them.
- No combinational path from inputs to outputs; all outputs are registered or state-decoded.

Test Plan:
- WIDTH=4; rst=1 for 2 cycles, then a=3, b=5, start pulse -> busy high 4 cycles, done pulse at 5th edge after accept, sum=8, cout=0.
- a=15, b=1 -> sum=0, cout=1. Then a=15, b=15 -> sum=14, cout=1. Then a=0, b=0 -> sum=0, cout=0.
- Hold start high continuously with a=7, b=9 -> accepted only in IDLE; done pulses every 6 cycles, each with sum=0, cout=1. Changing a/b during SHIFT has no effect on the result.
- Start a=6, b=6; assert rst for 1 cycle at the 2nd SHIFT cycle -> next cycle busy=0, done=0, sum=0, cout=0, no done pulse. A following start with a=1, b=2 yields sum=3, cout=0.
- Exhaustive sweep over all 256 a/b pairs (WIDTH=4) against a reference model of a+b -> zero mismatches; latency constant at 5 edges.
- WIDTH=1 build: pairs (0,0)/(0,1)/(1,0)/(1,1) -> (sum,cout) = (0,0)/(1,0)/(1,0)/(0,1), done 2 edges after accept.

Source files
------------

// File: rtl/serial_adder_if.sv
// serial_adder_if: request (start, operands) and result/status bundle for serial_adder
interface serial_adder_if #(parameter int WIDTH = 4);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
    logic             done;
    modport master (output start, a, b, input sum, cout, busy, done);
    modport slave  (input start, a, b, output sum, cout, busy, done);
endinterface

// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first unsigned adder built from one full-adder slice and a carry flop
module serial_adder #(parameter int WIDTH = 4) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d, cout_q, cout_d, s, c;
    assign s = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    assign c = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] | b_sh_q[0]));
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE: if (bus.start) begin
                a_sh_d  = bus.a;
                b_sh_d  = bus.b;
                sum_d   = '0;
                cnt_d   = '0;
                carry_d = 1'b0;
                cout_d  = 1'b0;
                state_d = SHIFT;
            end
            SHIFT: begin
                sum_d   = (sum_q >> 1) | (WIDTH'(s) << (WIDTH - 1));
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                carry_d = c;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    cout_d  = c;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.busy = (state_q == SHIFT);
    assign bus.done = (state_q == DONE);
endmodule
